// File: rtl/alu_cmd_sequencer_if.sv
// ALU command handshake between the command sequencer (master) and the
// ALU/regfile top (slave): start_cmd/op/rd/rs1/rs2 out, cmd_done/z/c back.
interface alu_cmd_sequencer_if;
  logic       start_cmd;
  logic [2:0] op_out;
  logic [2:0] rd_out;
  logic [2:0] rs1_out;
  logic [2:0] rs2_out;
  logic       cmd_done;
  logic       z_flag_in;
  logic       c_flag_in;

  modport master (
    output start_cmd, op_out, rd_out, rs1_out, rs2_out,
    input  cmd_done, z_flag_in, c_flag_in
  );

  modport slave (
    input  start_cmd, op_out, rd_out, rs1_out, rs2_out,
    output cmd_done, z_flag_in, c_flag_in
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: holds a small program of 12-bit ALU commands
// {op, rd, rs1, rs2} and issues them one at a time over the ALU command
// handshake, waiting for cmd_done between commands.
// Optional WAIT timeout enabled by defining ALU_SEQ_TIMEOUT_EN.
module alu_cmd_sequencer #(
  parameter int unsigned PROG_DEPTH  = 16,
  parameter int unsigned PC_W        = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [PC_W-1:0]     prog_addr,
  input  logic [11:0]         prog_wdata,
  input  logic [PC_W:0]       prog_len,
  input  logic                run,
  input  logic                abort,
  alu_cmd_sequencer_if.master cmd_if,
  output logic                busy,
  output logic                seq_done,
  output logic [PC_W-1:0]     pc_out,
  output logic                last_z,
  output logic                last_c,
  output logic                seq_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [PC_W:0] DepthL = (PC_W+1)'(PROG_DEPTH);

  logic [11:0]     mem [PROG_DEPTH];

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W:0]   len_q, len_d;
  logic [11:0]     cmd_q, cmd_d;
  logic            last_z_q, last_z_d;
  logic            last_c_q, last_c_d;
  logic            last_cmd;

`ifdef ALU_SEQ_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            tmo_hit;
  logic            seq_err_q, seq_err_d;

  assign tmo_hit = (tmo_q == TmoW'(TIMEOUT_CYC - 1));
`endif

  // len_q is at least 1 whenever a command is in flight, so len-1 never underflows there
  assign last_cmd = ({1'b0, pc_q} == (len_q - (PC_W+1)'(1)));

  // Program memory: written only while idle, out-of-range addresses dropped, never reset
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE) && (32'(prog_addr) < PROG_DEPTH)) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            state_d = (prog_len == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT: begin
          if (cmd_if.cmd_done) begin
            state_d = last_cmd ? S_DONE : S_FETCH;
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            state_d = S_ERR;
          end
`endif
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs decoded from the state register only, so rst clears start_cmd immediately
  always_comb begin
    cmd_if.start_cmd = (state_q == S_ISSUE);
    busy             = (state_q != S_IDLE);
    seq_done         = (state_q == S_DONE);
  end

  // Datapath next-state: pc/len/command/flags; abort freezes everything at last values
  always_comb begin
    pc_d     = pc_q;
    len_d    = len_q;
    cmd_d    = cmd_q;
    last_z_d = last_z_q;
    last_c_d = last_c_q;
`ifdef ALU_SEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
    seq_err_d = seq_err_q;
`endif
    if (!abort) begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
`ifdef ALU_SEQ_TIMEOUT_EN
            seq_err_d = 1'b0;
`endif
            if (prog_len != '0) begin
              len_d = (prog_len > DepthL) ? DepthL : prog_len;
              pc_d  = '0;
            end
          end
        end
        S_FETCH: cmd_d = mem[pc_q];
`ifdef ALU_SEQ_TIMEOUT_EN
        S_ISSUE: tmo_d = '0;
        S_ERR:   seq_err_d = 1'b1;
`endif
        S_WAIT: begin
          if (cmd_if.cmd_done) begin
            last_z_d = cmd_if.z_flag_in;
            last_c_d = cmd_if.c_flag_in;
            if (!last_cmd) begin
              pc_d = pc_q + PC_W'(1);
            end
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else begin
            tmo_d = tmo_q + TmoW'(1);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= '0;
      len_q    <= '0;
      cmd_q    <= '0;
      last_z_q <= 1'b0;
      last_c_q <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q     <= '0;
      seq_err_q <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      len_q    <= len_d;
      cmd_q    <= cmd_d;
      last_z_q <= last_z_d;
      last_c_q <= last_c_d;
`ifdef ALU_SEQ_TIMEOUT_EN
      tmo_q     <= tmo_d;
      seq_err_q <= seq_err_d;
`endif
    end
  end

  assign cmd_if.op_out  = cmd_q[11:9];
  assign cmd_if.rd_out  = cmd_q[8:6];
  assign cmd_if.rs1_out = cmd_q[5:3];
  assign cmd_if.rs2_out = cmd_q[2:0];
  assign pc_out         = pc_q;
  assign last_z         = last_z_q;
  assign last_c         = last_c_q;

`ifdef ALU_SEQ_TIMEOUT_EN
  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: a bench-side ALU/regfile responder
// answers commands with random latency; a reference model computes the
// expected command stream, final flags/pc and register file for each run.
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_wdata = '0;
  logic [4:0]  prog_len = '0;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic        busy, seq_done, last_z, last_c, seq_err;
  logic [3:0]  pc_out;

  alu_cmd_sequencer_if cif ();

  alu_cmd_sequencer #(
    .PROG_DEPTH  (16),
    .PC_W        (4),
    .TIMEOUT_CYC (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .prog_len   (prog_len),
    .run        (run),
    .abort      (abort),
    .cmd_if     (cif),
    .busy       (busy),
    .seq_done   (seq_done),
    .pc_out     (pc_out),
    .last_z     (last_z),
    .last_c     (last_c),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [11:0] cmd;
    logic        z;
    logic        c;
    logic [3:0]  pc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [7:0]  rf   [8];
  logic [7:0]  m_rf [8];
  logic [11:0] m_mem[16];
  logic        m_z = 1'b0;
  logic        m_c = 1'b0;
  logic [3:0]  m_pc = '0;
  bit          resp_mute = 1'b0;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // 8-bit ALU: bit 8 is carry (ADD), borrow (SUB) or shifted-out bit (SHL/SHR)
  function automatic logic [8:0] alu9(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {a, 1'b0};
      3'd6:    return {a[0], 1'b0, a[7:1]};
      default: return {1'b0, a};
    endcase
  endfunction

  // ALU responder: random latency, occasionally a stray cmd_done in the ISSUE cycle
  initial begin
    logic [11:0] c;
    logic [8:0]  t;
    cif.cmd_done  = 1'b0;
    cif.z_flag_in = 1'b0;
    cif.c_flag_in = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cif.start_cmd && !resp_mute && !rst) begin
        c = {cif.op_out, cif.rd_out, cif.rs1_out, cif.rs2_out};
        if ($urandom_range(0, 3) == 0) begin
          cif.cmd_done  = 1'b1;
          cif.z_flag_in = 1'($urandom);
          cif.c_flag_in = 1'($urandom);
        end
        repeat ($urandom_range(1, 4)) begin
          @(posedge clk); #1;
          cif.cmd_done = 1'b0;
        end
        t = alu9(c[11:9], rf[c[5:3]], rf[c[2:0]]);
        rf[c[8:6]]    = t[7:0];
        cif.z_flag_in = (t[7:0] == 8'h00);
        cif.c_flag_in = t[8];
        cif.cmd_done  = 1'b1;
        @(posedge clk); #1;
        cif.cmd_done  = 1'b0;
        cif.z_flag_in = 1'($urandom);
        cif.c_flag_in = 1'($urandom);
      end
    end
  end

  // Monitor: pops the scoreboard on start_cmd and seq_done, checks command stability at cmd_done
  initial begin
    exp_t        e;
    logic [11:0] lat;
    logic [11:0] cur;
    bit          outst;
    bit          ok;
    lat   = '0;
    outst = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outst = 1'b0;
      end else begin
        cur = {cif.op_out, cif.rd_out, cif.rs1_out, cif.rs2_out};
        if (abort) outst = 1'b0;
        if (cif.start_cmd) begin
          ok = (exp_q.size() > 0) && !exp_q[0].is_done;
          check_eq("start_cmd expected", 32'(ok), 32'd1);
          if (ok) begin
            e = exp_q.pop_front();
            check_eq("issued command", 32'(cur), 32'(e.cmd));
          end
          lat   = cur;
          outst = 1'b1;
        end else if (cif.cmd_done && outst) begin
          check_eq("command stable until cmd_done", 32'(cur), 32'(lat));
          outst = 1'b0;
        end
        if (seq_done) begin
          ok = (exp_q.size() > 0) && exp_q[0].is_done;
          check_eq("seq_done expected", 32'(ok), 32'd1);
          if (ok) begin
            e = exp_q.pop_front();
            check_eq("z/c/pc at seq_done", 32'({last_z, last_c, pc_out}), 32'({e.z, e.c, e.pc}));
          end
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, 32'({cif.start_cmd, cif.op_out, cif.rd_out, cif.rs1_out, cif.rs2_out,
                       busy, seq_done, pc_out, last_z, last_c, seq_err}), 32'd0);
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [11:0] d, input bit accept);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
    if (accept) m_mem[a] = d;
  endtask

  task automatic pulse_run(input logic [4:0] len);
    @(posedge clk); #1;
    prog_len = len; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Reference model: partial=1 means only the first command will be issued before an abort/reset/timeout
  task automatic start_run(input logic [4:0] len, input bit partial);
    int unsigned n;
    logic [8:0]  t;
    logic [11:0] c;
    exp_t        e;
    n = (len > 5'd16) ? 16 : 32'(len);
    if (partial) begin
      e.is_done = 1'b0; e.cmd = m_mem[0]; e.z = 1'b0; e.c = 1'b0; e.pc = '0;
      exp_q.push_back(e);
      m_pc = '0;
    end else begin
      m_rf = rf;
      for (int unsigned i = 0; i < n; i++) begin
        c = m_mem[i];
        t = alu9(c[11:9], m_rf[c[5:3]], m_rf[c[2:0]]);
        m_rf[c[8:6]] = t[7:0];
        m_z = (t[7:0] == 8'h00);
        m_c = t[8];
        e.is_done = 1'b0; e.cmd = c; e.z = 1'b0; e.c = 1'b0; e.pc = '0;
        exp_q.push_back(e);
      end
      if (n > 0) m_pc = 4'(n - 1);
      e.is_done = 1'b1; e.cmd = '0; e.z = m_z; e.c = m_c; e.pc = m_pc;
      exp_q.push_back(e);
    end
    pulse_run(len);
  endtask

  task automatic wait_idle(input string tag);
    int unsigned k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 2000);
    check_eq({tag, " busy drop"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, " scoreboard drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_rf(input string tag);
    int unsigned bad;
    bad = 0;
    for (int unsigned i = 0; i < 8; i++) if (rf[i] !== m_rf[i]) bad++;
    check_eq({tag, " regfile mismatches"}, bad, 32'd0);
  endtask

  task automatic wait_start_cmd(input string tag);
    int unsigned k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cif.start_cmd && k < 20);
    check_eq({tag, " start_cmd seen"}, 32'(cif.start_cmd), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    for (int unsigned i = 0; i < 8; i++) rf[i] = 8'(i * 17);

    // reset held 20ns
    #10;
    check_outputs_zero("outputs in reset");
    #10 rst = 1'b0;

    for (int unsigned a = 0; a < 16; a++) prog_write(4'(a), 12'($urandom), 1'b1);

    // len=0: seq_done only
    start_run(5'd0, 1'b0);
    wait_idle("len0");

    // ADD r4,r1,r2 ; SUB r5,r4,r2
    prog_write(4'd0, {3'd0, 3'd4, 3'd1, 3'd2}, 1'b1);
    prog_write(4'd1, {3'd1, 3'd5, 3'd4, 3'd2}, 1'b1);
    rf[1] = 8'h10; rf[2] = 8'h0A;
    start_run(5'd2, 1'b0);
    wait_idle("two-cmd");
    check_rf("two-cmd");
    check_eq("R4 after ADD", 32'(rf[4]), 32'h1A);
    check_eq("R5 after SUB", 32'(rf[5]), 32'h10);
    check_eq("pc_out after two-cmd", 32'(pc_out), 32'd1);

    // ADD r7,r3,r2 with carry out
    prog_write(4'd0, {3'd0, 3'd7, 3'd3, 3'd2}, 1'b1);
    rf[3] = 8'hFF; rf[2] = 8'h0A;
    start_run(5'd1, 1'b0);
    wait_idle("add-carry");
    check_eq("R7 after ADD", 32'(rf[7]), 32'h09);
    check_eq("c,z after ADD", 32'({last_c, last_z}), 32'b10);

    // SUB r6,r5,r1 to zero
    prog_write(4'd0, {3'd1, 3'd6, 3'd5, 3'd1}, 1'b1);
    rf[5] = 8'h10; rf[1] = 8'h10;
    start_run(5'd1, 1'b0);
    wait_idle("sub-zero");
    check_eq("R6 after SUB", 32'(rf[6]), 32'h00);
    check_eq("z after SUB", 32'(last_z), 32'd1);

    // abort in WAIT of command 1 of 3; writes and run while busy are ignored
    prog_write(4'd0, {3'd0, 3'd1, 3'd2, 3'd3}, 1'b1);
    prog_write(4'd1, {3'd4, 3'd2, 3'd1, 3'd0}, 1'b1);
    prog_write(4'd2, {3'd5, 3'd3, 3'd2, 3'd2}, 1'b1);
    resp_mute = 1'b1;
    start_run(5'd3, 1'b1);
    wait_start_cmd("abort run");
    repeat (2) @(posedge clk);
    prog_write(4'd0, 12'hFFF, 1'b0);
    pulse_run(5'd2);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_eq("busy after abort", 32'({busy, cif.start_cmd}), 32'd0);
    check_eq("z/c/pc held after abort", 32'({last_z, last_c, pc_out}), 32'({m_z, m_c, m_pc}));
    repeat (10) @(posedge clk);
    wait_idle("abort");

    // abort and run together while idle: abort wins
    @(posedge clk); #1;
    abort = 1'b1; run = 1'b1; prog_len = 5'd3;
    @(posedge clk); #1;
    abort = 1'b0; run = 1'b0;
    check_eq("busy after abort+run", 32'(busy), 32'd0);
    repeat (6) @(posedge clk);
    resp_mute = 1'b0;
    start_run(5'd3, 1'b0);
    wait_idle("after abort");
    check_rf("after abort");

    // prog_len above depth is clamped to 16 commands
    for (int unsigned a = 0; a < 16; a++) prog_write(4'(a), 12'($urandom), 1'b1);
    for (int unsigned i = 0; i < 8; i++) rf[i] = 8'($urandom);
    start_run(5'd20, 1'b0);
    wait_idle("clamp");
    check_rf("clamp");
    check_eq("pc_out after clamp", 32'(pc_out), 32'd15);

    // randomized programs
    for (int unsigned it = 0; it < 8; it++) begin
      for (int unsigned w = 0; w < 4; w++) prog_write(4'($urandom_range(0, 15)), 12'($urandom), 1'b1);
      for (int unsigned i = 0; i < 8; i++) rf[i] = 8'($urandom);
      start_run(5'($urandom_range(0, 18)), 1'b0);
      wait_idle("random");
      check_rf("random");
    end

    // reset in the middle of a command: start_cmd drops without a clock edge
    resp_mute = 1'b1;
    start_run(5'd2, 1'b1);
    wait_start_cmd("mid-reset");
    #2 rst = 1'b1;
    #1 check_outputs_zero("outputs on mid-op reset");
    #20 rst = 1'b0;
    m_z = 1'b0; m_c = 1'b0; m_pc = '0;
    exp_q.delete();
    resp_mute = 1'b0;
    start_run(5'd2, 1'b0);
    wait_idle("after reset");
    check_rf("after reset");

`ifdef ALU_SEQ_TIMEOUT_EN
    // silent responder: ERR after 64 WAIT cycles, seq_err sticky until next run
    resp_mute = 1'b1;
    start_run(5'd1, 1'b1);
    wait_start_cmd("timeout");
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 500);
    check_eq("cycles from start_cmd to idle on timeout", k, 32'd66);
    check_eq("seq_err/busy after timeout", 32'({seq_err, busy}), 32'b10);
    repeat (3) @(posedge clk);
    check_eq("seq_err sticky", 32'(seq_err), 32'd1);
    resp_mute = 1'b0;
    start_run(5'd0, 1'b0);
    check_eq("seq_err cleared by run", 32'(seq_err), 32'd0);
    wait_idle("after timeout");
`else
    k = 0;
    check_eq("seq_err without timeout", 32'(seq_err) + k, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
